l2_block_buffer: RTL and testbench
==================================

# l2_block_buffer

Transaction buffer between the L2 cache controller's memory port and the internal memory controller. It accepts single-word or whole-block read and write commands from L2 and stages write data in a FIFO. It issues one command at a time to memory, collects read data into a read FIFO and hands it back to L2 using the ready/ack strobes the controller already drives (`req_o`/`req_block_o`/`rw_o`/`add_o`, `write_o`/`data_o`, `read_o`/`data_i`).

## Interface
Parameters:
- `BW_ADDR`, 24: word-address width.
- `BW_BLOCK`, 2: log2 of words per block; the block is `2**BW_BLOCK` words.

Ports (clock and reset first):
- `clock_i`, in, 1: single clock; all state updates on its rising edge.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `req_i`, in, 1: command strobe from L2, accepted when `ready_req_o` is high.
- `req_block_i`, in, 1: 1 means block transfer, 0 means single word.
- `rw_i`, in, 1: 1 means write, 0 means read.
- `add_i`, in, BW_ADDR: word address. Block commands ignore the low BW_BLOCK bits; the buffer forces them to 0.
- `ready_req_o`, out, 1: buffer can accept a command.
- `write_i`, in, 1: L2 pushes `wdata_i` into the write FIFO.
- `wdata_i`, in, 32: write data.
- `ready_write_o`, out, 1: write FIFO not full.
- `read_i`, in, 1: L2 pops the read FIFO.
- `rdata_o`, out, 32: head of the read FIFO (first-word fall-through).
- `ready_read_o`, out, 1: read FIFO not empty.
- `mem_req_o`, out, 1: command valid to memory.
- `mem_rw_o`, out, 1: command direction.
- `mem_add_o`, out, BW_ADDR: current word address.
- `mem_ready_i`, in, 1: memory accepts the word beat presented this cycle.
- `mem_wdata_o`, out, 32: write beat data.
- `mem_rvalid_i`, in, 1: read beat valid.
- `mem_rdata_i`, in, 32: read beat data.

## Operation
- Both FIFOs are `2**BW_BLOCK` deep, with `BW_BLOCK+1`-bit pointers and full/empty detected by MSB compare.
- Command register holds rw, block, base address, and a beat count `N` (N = `2**BW_BLOCK` for block commands, 1 otherwise).
- IDLE:
  - `ready_req_o` = 1 only if IDLE and the read FIFO is empty.
  - On `req_i` & `ready_req_o`, latch the command, clear the beat counter, and go to WR if `rw_i`, else RD.
- WR:
  - `mem_req_o` = 1 while the write FIFO is non-empty.
  - `mem_wdata_o` = FIFO head; `mem_add_o` = base + beat.
  - On `mem_ready_i` & `mem_req_o`: pop the FIFO and increment the beat.
  - When beat reaches N-1 and is accepted, go to IDLE.
  - L2 may push write data before, during, or after the command. Pushes are legal in any state while not full.
- RD:
  - `mem_req_o` = 1 and `mem_add_o` = base + beat until N beats have been requested.
  - Each `mem_rvalid_i` pushes `mem_rdata_i`. When N words have been received, go to DRAIN.
- DRAIN: wait until the read FIFO is empty (L2 pops via `read_i`), then go to IDLE.
- Error handling:
  - `read_i` while empty: ignored.
  - `write_i` while full: ignored, data dropped.
  - `mem_rvalid_i` outside RD: ignored.
  - `mem_rvalid_i` with the read FIFO full cannot occur, because depth is N.
- Simultaneous push and pop on a non-empty FIFO: both happen and occupancy is unchanged.

## Timing
- Reset values:
  - All outputs 0 except `ready_req_o` = 1, `ready_write_o` = 1, `ready_read_o` = 0.
  - State is IDLE, pointers are 0.
  - `rdata_o` and `mem_wdata_o` are 0 after reset; thereafter they are don't-care while the FIFO is empty.
- Command acceptance to `mem_req_o` high: 1 cycle. A write command with an empty write FIFO raises `mem_req_o` on the cycle after the first push.
- Memory beat to `ready_read_o`: 1 cycle after the `mem_rvalid_i` edge.
- `ready_*` outputs are registered-state functions. They never depend combinationally on `req_i`, `write_i` or `read_i`.
- Reset asserted mid-transaction aborts immediately: FIFOs are flushed and no further `mem_req_o` is issued.

## Configuration
- `L2_BLOCK_BUFFER_PERF_EN` defined:
  - Adds 32-bit saturating counters `perf_rd_blocks`, `perf_wr_blocks` and `perf_stall_cycles` (cycles with `mem_req_o` & !`mem_ready_i`).
  - Adds output port `perf_o`, 32 bits, and input `perf_sel_i`, 2 bits, selecting counter 0/1/2; selection 3 returns 0.
  - Counters clear on reset.
- Undefined: counters and both ports are absent; function is otherwise identical.

## Test plan
- Reset, then block read at 0x000105: `mem_add_o` steps 0x104..0x107. Memory returns 0xA0..0xA3; L2 pops 0xA0..0xA3 in order. `ready_req_o` returns to 1 only after the last pop.
- Block write with all 4 words (0x11..0x44) pushed before `req_i` at 0x200: 4 beats at 0x200..0x203 with data 0x11..0x44.
- Block write where data trickles in 1 word every 3 cycles: `mem_req_o` drops between words, and the beat count still ends at 4.
- Single-word write at 0x3FF with `mem_ready_i` stalled 5 cycles: `mem_add_o` and `mem_wdata_o` are held stable; exactly 1 beat completes.
- Push 5 words: the 5th is dropped and `ready_write_o` = 0 after 4. Assert `reset_i` during RD after 2 beats: all outputs return to reset values within the same cycle.
- With `L2_BLOCK_BUFFER_PERF_EN`: 2 block reads and 1 block write give `perf_o` = 2/1 for selections 0/1.

Source files
------------

// File: rtl/l2_block_buffer.sv
// l2_block_buffer
//   Transaction buffer between the L2 cache controller memory port and the
//   internal memory controller. L2 issues single-word or whole-block read and
//   write commands. Write data is staged in a write FIFO. The buffer issues one
//   command at a time to memory and collects read beats in a read FIFO, which L2
//   drains through first-word fall-through.
//
// Ports
//   clock_i, reset_i            : clock and asynchronous active-high reset
//   req_i, req_block_i, rw_i,   : command strobe, block/word, write/read and
//   add_i, ready_req_o          :   word address, plus command-accept ready
//   write_i, wdata_i,           : push into the write FIFO, plus not-full flag
//   ready_write_o
//   read_i, rdata_o,            : pop from the read FIFO, head data and
//   ready_read_o                :   not-empty flag
//   mem_req_o, mem_rw_o,        : one word beat per cycle towards memory
//   mem_add_o, mem_wdata_o,
//   mem_ready_i
//   mem_rvalid_i, mem_rdata_i   : read beats returned by memory
//
// Optional feature (macro L2_BLOCK_BUFFER_PERF_EN)
//   Adds the perf_sel_i / perf_o ports and three saturating 32-bit counters:
//   accepted block reads, accepted block writes and memory stall cycles.
//   perf_sel_i = 3 returns 0. The default build omits all of it.

module l2_block_buffer #(
  parameter int BW_ADDR  = 24,
  parameter int BW_BLOCK = 2
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               req_i,
  input  logic               req_block_i,
  input  logic               rw_i,
  input  logic [BW_ADDR-1:0] add_i,
  output logic               ready_req_o,
  input  logic               write_i,
  input  logic [31:0]        wdata_i,
  output logic               ready_write_o,
  input  logic               read_i,
  output logic [31:0]        rdata_o,
  output logic               ready_read_o,
  output logic               mem_req_o,
  output logic               mem_rw_o,
  output logic [BW_ADDR-1:0] mem_add_o,
  input  logic               mem_ready_i,
  output logic [31:0]        mem_wdata_o,
  input  logic               mem_rvalid_i,
  input  logic [31:0]        mem_rdata_i
`ifdef L2_BLOCK_BUFFER_PERF_EN
  ,
  input  logic [1:0]         perf_sel_i,
  output logic [31:0]        perf_o
`endif
);

  localparam int DEPTH = 2 ** BW_BLOCK;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DRAIN
  } state_t;

  state_t state;

  // Command register. cmd_last is the index of the final beat (N-1), so a
  // block command holds all ones and a single-word command holds zero.
  logic               cmd_rw;
  logic [BW_ADDR-1:0] cmd_base;
  logic [BW_BLOCK-1:0] cmd_last;
  // beat counts requested/accepted beats and needs one extra bit so that a read
  // can tell "all N beats requested" apart from "beat N-1 pending".
  logic [BW_BLOCK:0]   beat;
  logic [BW_BLOCK-1:0] rcv_cnt;

  // FIFO storage with one extra pointer bit for full/empty disambiguation.
  logic [31:0]       wmem [DEPTH];
  logic [BW_BLOCK:0] w_wptr, w_rptr;
  logic [31:0]       rmem [DEPTH];
  logic [BW_BLOCK:0] r_wptr, r_rptr;

  logic w_empty, w_full, r_empty, r_full;
  logic accept, beat_done;
  logic w_push, w_pop, r_push, r_pop;

  // Flags, handshakes and outputs are all decoded from registered state, so
  // none of the ready outputs can see req_i, write_i or read_i combinationally.
  always_comb begin
    w_empty = (w_wptr == w_rptr);
    w_full  = (w_wptr[BW_BLOCK] != w_rptr[BW_BLOCK]) &&
              (w_wptr[BW_BLOCK-1:0] == w_rptr[BW_BLOCK-1:0]);
    r_empty = (r_wptr == r_rptr);
    r_full  = (r_wptr[BW_BLOCK] != r_rptr[BW_BLOCK]) &&
              (r_wptr[BW_BLOCK-1:0] == r_rptr[BW_BLOCK-1:0]);

    ready_req_o   = (state == S_IDLE) && r_empty;
    ready_write_o = !w_full;
    ready_read_o  = !r_empty;
    rdata_o       = rmem[r_rptr[BW_BLOCK-1:0]];
    mem_wdata_o   = wmem[w_rptr[BW_BLOCK-1:0]];

    mem_req_o = ((state == S_WR) && !w_empty) ||
                ((state == S_RD) && (beat <= {1'b0, cmd_last}));
    mem_rw_o  = cmd_rw;
    mem_add_o = cmd_base + BW_ADDR'(beat);

    accept    = req_i && ready_req_o;
    beat_done = mem_req_o && mem_ready_i;
    w_push    = write_i && !w_full;
    w_pop     = (state == S_WR) && beat_done;
    r_push    = (state == S_RD) && mem_rvalid_i && !r_full;
    r_pop     = read_i && !r_empty;
  end

  // Write FIFO: L2 may push in any state; the WR state pops one word per
  // accepted memory beat. Push and pop in the same cycle both take effect.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      w_wptr <= '0;
      w_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) wmem[i] <= '0;
    end else begin
      if (w_push) begin
        wmem[w_wptr[BW_BLOCK-1:0]] <= wdata_i;
        w_wptr <= w_wptr + 1'b1;
      end
      if (w_pop) w_rptr <= w_rptr + 1'b1;
    end
  end

  // Read FIFO: filled by memory read beats while in RD, drained by L2. The
  // storage is cleared on reset so that rdata_o reads 0 right after reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) rmem[i] <= '0;
    end else begin
      if (r_push) begin
        rmem[r_wptr[BW_BLOCK-1:0]] <= mem_rdata_i;
        r_wptr <= r_wptr + 1'b1;
      end
      if (r_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Command sequencer. Reads track requested beats (beat) and returned beats
  // (rcv_cnt) separately because memory may return data several cycles after
  // accepting the request. DRAIN holds off new commands until L2 has emptied
  // the read FIFO.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      cmd_rw   <= 1'b0;
      cmd_base <= '0;
      cmd_last <= '0;
      beat     <= '0;
      rcv_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd_rw   <= rw_i;
            cmd_last <= req_block_i ? '1 : '0;
            cmd_base <= req_block_i ? {add_i[BW_ADDR-1:BW_BLOCK], {BW_BLOCK{1'b0}}}
                                    : add_i;
            beat     <= '0;
            rcv_cnt  <= '0;
            state    <= rw_i ? S_WR : S_RD;
          end
        end
        S_WR: begin
          if (beat_done) begin
            beat <= beat + 1'b1;
            if (beat == {1'b0, cmd_last}) state <= S_IDLE;
          end
        end
        S_RD: begin
          if (beat_done) beat <= beat + 1'b1;
          if (r_push) begin
            rcv_cnt <= rcv_cnt + 1'b1;
            if (rcv_cnt == cmd_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_empty) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef L2_BLOCK_BUFFER_PERF_EN
  logic [31:0] perf_rd_blocks;
  logic [31:0] perf_wr_blocks;
  logic [31:0] perf_stall_cycles;

  // Saturating event counters. Blocks are counted when the command is accepted.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      perf_rd_blocks    <= '0;
      perf_wr_blocks    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (accept && req_block_i && !rw_i && (perf_rd_blocks != '1))
        perf_rd_blocks <= perf_rd_blocks + 1'b1;
      if (accept && req_block_i && rw_i && (perf_wr_blocks != '1))
        perf_wr_blocks <= perf_wr_blocks + 1'b1;
      if (mem_req_o && !mem_ready_i && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end

  // Counter readback selection.
  always_comb begin
    perf_o = '0;
    case (perf_sel_i)
      2'd0:    perf_o = perf_rd_blocks;
      2'd1:    perf_o = perf_wr_blocks;
      2'd2:    perf_o = perf_stall_cycles;
      default: perf_o = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_l2_block_buffer.sv
// tb_l2_block_buffer
//   Self-checking bench for l2_block_buffer. A transaction-level reference model
//   (queues for both FIFOs, a beat count per command and an associative-array
//   memory) predicts every output each cycle. Directed scenarios come first,
//   then a run of randomized commands with random memory stalls and latencies.
//   Outputs are sampled on the falling edge; inputs change there too.

module tb_l2_block_buffer;

  localparam int BW_ADDR  = 24;
  localparam int BW_BLOCK = 2;
  localparam int DEPTH    = 4;

  logic                clock_i = 1'b0;
  logic                reset_i;
  logic                req_i, req_block_i, rw_i;
  logic [BW_ADDR-1:0]  add_i;
  logic                ready_req_o;
  logic                write_i;
  logic [31:0]         wdata_i;
  logic                ready_write_o;
  logic                read_i;
  logic [31:0]         rdata_o;
  logic                ready_read_o;
  logic                mem_req_o, mem_rw_o;
  logic [BW_ADDR-1:0]  mem_add_o;
  logic                mem_ready_i;
  logic [31:0]         mem_wdata_o;
  logic                mem_rvalid_i;
  logic [31:0]         mem_rdata_i;
`ifdef L2_BLOCK_BUFFER_PERF_EN
  logic [1:0]          perf_sel_i = 2'd0;
  logic [31:0]         perf_o;
`endif

  always #5 clock_i = ~clock_i;

  l2_block_buffer #(
    .BW_ADDR  (BW_ADDR),
    .BW_BLOCK (BW_BLOCK)
  ) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .req_i         (req_i),
    .req_block_i   (req_block_i),
    .rw_i          (rw_i),
    .add_i         (add_i),
    .ready_req_o   (ready_req_o),
    .write_i       (write_i),
    .wdata_i       (wdata_i),
    .ready_write_o (ready_write_o),
    .read_i        (read_i),
    .rdata_o       (rdata_o),
    .ready_read_o  (ready_read_o),
    .mem_req_o     (mem_req_o),
    .mem_rw_o      (mem_rw_o),
    .mem_add_o     (mem_add_o),
    .mem_ready_i   (mem_ready_i),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
`ifdef L2_BLOCK_BUFFER_PERF_EN
   ,.perf_sel_i    (perf_sel_i),
    .perf_o        (perf_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 writing, 2 reading, 3 draining.
  int                 mPhase;
  logic [BW_ADDR-1:0] mBase;
  int                 mN, mBeats, mRcv;
  logic [31:0]        wq[$];
  logic [31:0]        rq[$];
  logic [BW_ADDR-1:0] pendQ[$];
  logic [31:0]        memArr[int];
  int                 perfRd, perfWr, perfStall;

  // Scenario knobs.
  bit                 cmdPending, cmdBlock, cmdRw, reqAfterPush, spurious;
  logic [BW_ADDR-1:0] cmdAddr;
  logic [31:0]        toPush[$];
  int                 pushGap, gapLeft, stallPct, stallLeft, rvalidPct, popPct;
  int                 obsBeats;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBound(input string tag, input int used, input int budget);
    checks++;
    assert (used < budget) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d cycles expected fewer than %0d", tag, used, budget);
    end
  endtask

  function automatic logic expMemReq();
    return (mPhase == 1 && wq.size() > 0) || (mPhase == 2 && mBeats < mN);
  endfunction

  task automatic modelReset();
    mPhase = 0; mBase = '0; mN = 1; mBeats = 0; mRcv = 0;
    wq.delete(); rq.delete(); pendQ.delete(); toPush.delete();
    perfRd = 0; perfWr = 0; perfStall = 0;
    cmdPending = 0; stallLeft = 0; gapLeft = 0; spurious = 0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_ready_req",   32'(ready_req_o),   32'd1);
    checkOutput("rst_ready_write", 32'(ready_write_o), 32'd1);
    checkOutput("rst_ready_read",  32'(ready_read_o),  32'd0);
    checkOutput("rst_mem_req",     32'(mem_req_o),     32'd0);
    checkOutput("rst_mem_rw",      32'(mem_rw_o),      32'd0);
    checkOutput("rst_mem_add",     32'(mem_add_o),     32'd0);
    checkOutput("rst_rdata",       rdata_o,            32'd0);
    checkOutput("rst_mem_wdata",   mem_wdata_o,        32'd0);
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic checkCycle();
    logic emr;
    emr = expMemReq();
    checkOutput("ready_req_o",   32'(ready_req_o),   32'(mPhase == 0 && rq.size() == 0));
    checkOutput("ready_write_o", 32'(ready_write_o), 32'(wq.size() < DEPTH));
    checkOutput("ready_read_o",  32'(ready_read_o),  32'(rq.size() > 0));
    checkOutput("mem_req_o",     32'(mem_req_o),     32'(emr));
    if (emr) begin
      checkOutput("mem_add_o", 32'(mem_add_o), 32'(mBase + 24'(mBeats)));
      checkOutput("mem_rw_o",  32'(mem_rw_o),  32'(mPhase == 1));
      if (mPhase == 1) checkOutput("mem_wdata_o", mem_wdata_o, wq[0]);
    end
    if (rq.size() > 0) checkOutput("rdata_o", rdata_o, rq[0]);
  endtask

  // Drive L2 and memory-side inputs for the coming rising edge.
  task automatic applyStimulus();
    req_i = 1'b0;
    req_block_i = 1'($urandom_range(1));
    rw_i        = 1'($urandom_range(1));
    add_i       = 24'($urandom);
    if (cmdPending && !(reqAfterPush && toPush.size() > 0)) begin
      req_i = 1'b1; req_block_i = cmdBlock; rw_i = cmdRw; add_i = cmdAddr;
    end
    write_i = 1'b0;
    wdata_i = $urandom;
    if (toPush.size() > 0) begin
      if (gapLeft == 0) begin
        write_i = 1'b1; wdata_i = toPush[0]; gapLeft = pushGap;
      end else gapLeft--;
    end
    if (stallLeft > 0 && expMemReq()) begin
      mem_ready_i = 1'b0; stallLeft--;
    end else mem_ready_i = ($urandom_range(99) >= stallPct);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
    if (mPhase == 2 && pendQ.size() > 0 && $urandom_range(99) < rvalidPct) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = memArr[int'(pendQ[0])];
    end else if (spurious && mPhase != 2 && $urandom_range(3) == 0) mem_rvalid_i = 1'b1;
    read_i = ($urandom_range(99) < popPct);
  endtask

  // Advance the model across one rising edge using pre-edge values.
  task automatic modelUpdate();
    int prePhase, preW, preR, a;
    logic emr, beatAcc;
    prePhase = mPhase; preW = wq.size(); preR = rq.size();
    emr = expMemReq();
    beatAcc = emr && mem_ready_i;
    if (emr && !mem_ready_i) perfStall++;
    case (prePhase)
      0: if (req_i && preR == 0) begin
           mN = req_block_i ? DEPTH : 1;
           mBase = req_block_i ? {add_i[BW_ADDR-1:2], 2'b00} : add_i;
           mBeats = 0; mRcv = 0; cmdPending = 0;
           mPhase = rw_i ? 1 : 2;
           if (req_block_i) begin
             if (rw_i) perfWr++; else perfRd++;
           end
         end
      1: if (beatAcc) begin
           memArr[int'(mBase + 24'(mBeats))] = wq[0];
           mBeats++;
           if (mBeats == mN) mPhase = 0;
         end
      2: begin
           if (mem_rvalid_i) begin
             mRcv++;
             if (mRcv == mN) mPhase = 3;
           end
           if (beatAcc) begin
             a = int'(mBase + 24'(mBeats));
             if (!memArr.exists(a)) memArr[a] = $urandom;
             pendQ.push_back(24'(a));
             mBeats++;
           end
         end
      default: if (preR == 0) mPhase = 0;
    endcase
    if (prePhase == 1 && beatAcc) void'(wq.pop_front());
    if (write_i && preW < DEPTH) wq.push_back(wdata_i);
    if (write_i) void'(toPush.pop_front());
    if (read_i && preR > 0) void'(rq.pop_front());
    if (prePhase == 2 && mem_rvalid_i) rq.push_back(memArr[int'(pendQ.pop_front())]);
  endtask

  task automatic stepCycle();
    checkCycle();
    applyStimulus();
    if (mem_req_o && mem_ready_i) obsBeats++;
    modelUpdate();
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic runUntilIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(mPhase == 0 && !cmdPending && toPush.size() == 0 && wq.size() == 0 &&
             rq.size() == 0) && n < budget) begin
      stepCycle();
      n++;
    end
    checkBound(tag, n, budget);
    stepCycle();
  endtask

  task automatic setCmd(input bit rw, input bit block, input logic [BW_ADDR-1:0] addr);
    cmdPending = 1; cmdRw = rw; cmdBlock = block; cmdAddr = addr;
  endtask

`ifdef L2_BLOCK_BUFFER_PERF_EN
  task automatic checkPerf();
    perf_sel_i = 2'd0; #1 checkOutput("perf_rd_blocks", perf_o, 32'(perfRd));
    perf_sel_i = 2'd1; #1 checkOutput("perf_wr_blocks", perf_o, 32'(perfWr));
    perf_sel_i = 2'd2; #1 checkOutput("perf_stall",     perf_o, 32'(perfStall));
    perf_sel_i = 2'd3; #1 checkOutput("perf_sel3",      perf_o, 32'd0);
  endtask
`endif

  initial begin
    int g;
    reset_i = 1'b1;
    req_i = 0; req_block_i = 0; rw_i = 0; add_i = '0; write_i = 0; wdata_i = '0;
    read_i = 0; mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    stallPct = 0; rvalidPct = 100; popPct = 0; pushGap = 0; reqAfterPush = 0;
    modelReset();
    repeat (2) @(negedge clock_i);
    checkResetValues();
    reset_i = 1'b0;
    @(negedge clock_i);

    $display("[TB] block read at 0x000105");
    for (int i = 0; i < 4; i++) memArr[32'h104 + i] = 32'hA0 + 32'(i);
    popPct = 40;
    setCmd(0, 1, 24'h000105);
    runUntilIdle("block_read", 200);

    $display("[TB] block write, data staged first");
    popPct = 20;
    toPush = '{32'h11, 32'h22, 32'h33, 32'h44};
    reqAfterPush = 1; obsBeats = 0;
    setCmd(1, 1, 24'h000200);
    runUntilIdle("block_write", 200);
    checkOutput("block_write_beats", 32'(obsBeats), 32'd4);

    $display("[TB] block write, data trickles in");
    for (int i = 0; i < 4; i++) toPush.push_back($urandom);
    reqAfterPush = 0; pushGap = 2; gapLeft = 0; obsBeats = 0;
    setCmd(1, 1, 24'h000342);
    runUntilIdle("trickle_write", 200);
    checkOutput("trickle_beats", 32'(obsBeats), 32'd4);

    $display("[TB] single write at 0x3FF with stalled memory");
    toPush.push_back(32'hCAFE_0001);
    reqAfterPush = 1; pushGap = 0; stallLeft = 5; obsBeats = 0;
    setCmd(1, 0, 24'h0003FF);
    runUntilIdle("stalled_write", 200);
    checkOutput("stalled_beats", 32'(obsBeats), 32'd1);

    $display("[TB] write FIFO overflow");
    for (int i = 0; i < 5; i++) toPush.push_back(32'h5000 + 32'(i));
    repeat (6) stepCycle();
    checkOutput("overflow_ready_write", 32'(ready_write_o), 32'd0);
    reqAfterPush = 0;
    setCmd(1, 1, 24'h000400);
    runUntilIdle("overflow_write", 200);

    $display("[TB] reset during block read");
    popPct = 0; rvalidPct = 100;
    setCmd(0, 1, 24'h000500);
    g = 0;
    while (mRcv < 2 && g < 50) begin
      stepCycle();
      g++;
    end
    checkBound("reach_two_beats", g, 50);
    #2 reset_i = 1'b1;
    req_i = 0; write_i = 0; read_i = 0; mem_rvalid_i = 0;
    #1 checkResetValues();
    modelReset();
    @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
    checkResetValues();

    $display("[TB] two block reads and one block write");
    popPct = 60; stallPct = 20;
    setCmd(0, 1, 24'h000600); runUntilIdle("perf_rd0", 200);
    setCmd(0, 1, 24'h000700); runUntilIdle("perf_rd1", 200);
    for (int i = 0; i < 4; i++) toPush.push_back($urandom);
    setCmd(1, 1, 24'h000800); runUntilIdle("perf_wr0", 200);
`ifdef L2_BLOCK_BUFFER_PERF_EN
    checkPerf();
`endif

    $display("[TB] randomized commands");
    spurious = 1;
    for (int t = 0; t < 40; t++) begin
      stallPct = $urandom_range(0, 50);
      rvalidPct = $urandom_range(30, 100);
      popPct = $urandom_range(20, 100);
      pushGap = $urandom_range(0, 3);
      gapLeft = 0;
      reqAfterPush = 1'($urandom_range(1));
      setCmd(1'($urandom_range(1)), 1'($urandom_range(1)), 24'($urandom_range(0, 4095)));
      if (cmdRw) for (int i = 0; i < (cmdBlock ? DEPTH : 1); i++) toPush.push_back($urandom);
      runUntilIdle("random_txn", 400);
    end
`ifdef L2_BLOCK_BUFFER_PERF_EN
    checkPerf();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
